// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for the 5-stage MIPS core.
// The block handles three cases:
//   - load-use bubbles
//   - front-end flushes on EX redirects
//   - whole-pipe freeze while data memory is pending
// It also runs a memory-timeout watchdog and keeps saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             hazard,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t            state, stateNext;
  logic [WCNT_W-1:0] wCnt, wCntNext;
  logic              freeze, loadUse, stallInc, flushInc;

  // The freeze condition depends on the FSM state.
  // The load-use match never fires on $0.
  always_comb begin
    freeze  = (state == ERR) ||
              (state == RUN      && dmem_req && !dmem_ready) ||
              (state == MEM_WAIT && !dmem_ready);
    loadUse = ex_memread && (ex_rt != 5'd0) &&
              ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
  end

  // Control outputs are resolved by priority: rst, freeze, redirect, load-use.
  always_comb begin
    hazard      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      hazard     = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      hazard     = 1'b1;
    end else if (loadUse) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      hazard     = 1'b1;
    end
  end

  // Next-state logic for the memory-wait FSM.
  // wCnt counts the not-ready cycles of the current access.
  always_comb begin
    stateNext = state;
    wCntNext  = wCnt;
    case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          stateNext = MEM_WAIT;
          wCntNext  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          stateNext = RUN;
          wCntNext  = '0;
        end else if (wCnt == WCNT_MAX) begin
          stateNext = ERR;
        end else begin
          wCntNext = wCnt + WCNT_W'(1);
        end
      end
      ERR:     stateNext = ERR;
      default: begin
        stateNext = RUN;
        wCntNext  = '0;
      end
    endcase
  end

  // State register. ERR is left only through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wCnt  <= '0;
    end else begin
      state <= stateNext;
      wCnt  <= wCntNext;
    end
  end

  assign mem_err  = (state == ERR);
  assign stallInc = (freeze && state != ERR) || (loadUse && !freeze && !ex_redirect);
  assign flushInc = !freeze && ex_redirect;

  // Performance counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallInc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      if (flushInc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
